additionneur_pipeline: RTL and testbench
========================================

ADDITIONNEUR_PIPELINE -- requirements
Module: additionneur_pipeline

Interface
REQ-001 Parameter WIDTH, default 32, operand and result width in bits.
REQ-002 Parameter SEG_WIDTH, default 16, bits added per pipeline stage; WIDTH SHALL be an integer multiple of SEG_WIDTH; NSEG = WIDTH/SEG_WIDTH.
REQ-003 clk  input  1  single clock; all registers on rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 in_valid  input  1  operands and mode presented.
REQ-006 in_ready  output  1  block accepts operands this cycle.
REQ-007 a  input  WIDTH  operand A.
REQ-008 b  input  WIDTH  operand B.
REQ-009 rin  input  1  carry-in, used when sub=0.
REQ-010 sub  input  1  0: s = a + b + rin; 1: s = a - b (rin ignored).
REQ-011 out_valid  output  1  result presented.
REQ-012 out_ready  input  1  consumer accepts result this cycle.
REQ-013 s  output  WIDTH  sum/difference modulo 2^WIDTH.
REQ-014 rout  output  1  carry-out of MSB (for sub: 1 = no borrow).
REQ-015 ovf  output  1  two's-complement signed overflow of the operation.

Function
REQ-016 Transfer on input side SHALL occur when in_valid && in_ready; on output side when out_valid && out_ready.
REQ-017 Pipeline SHALL have NSEG stages; stage k adds segment k (bits k*SEG_WIDTH..(k+1)*SEG_WIDTH-1) with carry registered from stage k-1; stage 0 carry-in = sub ? 1 : rin.
REQ-018 For sub=1, b SHALL be bitwise inverted at acceptance before entering stage 0.
REQ-019 Not-yet-added upper segments and already-computed lower result segments SHALL be carried forward in per-stage registers (skew/deskew) so all WIDTH result bits of one operation appear together.
REQ-020 Latency SHALL be exactly NSEG cycles from input transfer to out_valid, absent backpressure.
REQ-021 Throughput SHALL be one operation per cycle when out_ready is held high.
REQ-022 Stall: pipeline advance enable = !out_valid || out_ready; when disabled, all stage registers and valid bits SHALL hold.
REQ-023 in_ready SHALL equal the advance enable (combinational from out_valid, out_ready); no dependency of in_ready on in_valid.
REQ-024 Bubbles (invalid stages) SHALL advance with the pipeline; no bubble collapse required.
REQ-025 s, rout, ovf SHALL remain stable while out_valid && !out_ready.
REQ-026 ovf = carry into MSB XOR carry out of MSB, computed in last stage.
REQ-027 Simultaneous input and output transfer in the same cycle SHALL be lossless.
REQ-028 NSEG=1 SHALL degenerate to a single registered adder with latency 1.

Reset
REQ-029 On rst, all stage valid bits SHALL clear immediately; out_valid=0, s=0, rout=0, ovf=0.
REQ-030 in_ready SHALL be 1 while rst is high released-state (pipeline empty); operations in flight at reset are discarded, none emitted after.
REQ-031 Data registers other than outputs need no reset.

Structure
REQ-032 Default WIDTH/SEG_WIDTH constants SHALL live in a shared package/header additionneur_pkg also used by regression datapath blocks.
REQ-033 One sub-module additionneur_segment (combinational SEG_WIDTH adder: a, b, rin -> s, rout, plus carry into MSB) SHALL be instantiated NSEG times via generate.

Verification (WIDTH=32, SEG_WIDTH=16)
REQ-034 a=0x0000FFFF, b=0x00000001, rin=0, sub=0 -> after 2 cycles s=0x00010000, rout=0, ovf=0 (cross-segment carry).
REQ-035 a=0x7FFFFFFF, b=1, sub=0 -> s=0x80000000, ovf=1, rout=0; a=5, b=7, sub=1 -> s=0xFFFFFFFE, rout=0, ovf=0.
REQ-036 a=0xFFFFFFFF, b=0, rin=1 -> s=0, rout=1; back-to-back 100 random ops with out_ready=1 -> one result per cycle, in order, matching reference model.
REQ-037 Hold out_ready=0 for 5 cycles with pipeline full -> in_ready=0, outputs stable, no loss/duplication after release.
REQ-038 Assert rst with 2 ops in flight -> out_valid=0 same cycle, no result emitted later; first op after release has 2-cycle latency.

Source files
------------

// File: rtl/additionneur_pkg.sv
// -----------------------------------------------------------------------------
// additionneur_pkg
// Shared constants and types for the segmented pipelined adder and for any
// regression datapath block that needs the same default operand geometry.
//   ADD_WIDTH     : default operand/result width in bits
//   ADD_SEG_WIDTH : default number of bits added per pipeline stage
//   op_e          : operation selector carried on the 'sub' input
//   nseg()        : number of pipeline stages for a given geometry
// -----------------------------------------------------------------------------
package additionneur_pkg;

  localparam int unsigned ADD_WIDTH     = 32'd32;
  localparam int unsigned ADD_SEG_WIDTH = 32'd16;

  typedef enum logic {
    OP_ADD = 1'b0,
    OP_SUB = 1'b1
  } op_e;

  // Stage count; callers keep WIDTH an exact multiple of SEG_WIDTH.
  function automatic int unsigned nseg(input int unsigned width,
                                       input int unsigned seg_width);
    return width / seg_width;
  endfunction

endpackage

// File: rtl/additionneur_pipeline_if.sv
// -----------------------------------------------------------------------------
// additionneur_pipeline_if
// Operand and result handshake bundle of the pipelined adder.
//   in_valid/in_ready   : operand-side valid/ready handshake
//   a, b, rin, sub      : operands, carry-in and add/subtract select
//   out_valid/out_ready : result-side valid/ready handshake
//   s, rout, ovf        : result, carry-out of MSB, signed overflow
// Modports:
//   master : producer of operands / consumer of results (environment side)
//   slave  : the adder itself
// -----------------------------------------------------------------------------
interface additionneur_pipeline_if
  import additionneur_pkg::*;
#(
  parameter int unsigned WIDTH = ADD_WIDTH
) ();

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             rin;
  logic             sub;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] s;
  logic             rout;
  logic             ovf;

  modport master (
    output in_valid, a, b, rin, sub, out_ready,
    input  in_ready, out_valid, s, rout, ovf
  );

  modport slave (
    input  in_valid, a, b, rin, sub, out_ready,
    output in_ready, out_valid, s, rout, ovf
  );

endinterface

// File: rtl/additionneur_segment.sv
// -----------------------------------------------------------------------------
// additionneur_segment
// Purely combinational SEG_WIDTH-bit adder slice.
//   a_i, b_i : segment operands
//   rin_i    : carry into the segment LSB
//   s_o      : segment sum
//   rout_o   : carry out of the segment MSB
//   cmsb_o   : carry into the segment MSB (used for signed overflow)
// -----------------------------------------------------------------------------
module additionneur_segment
  import additionneur_pkg::*;
#(
  parameter int unsigned SEG_WIDTH = ADD_SEG_WIDTH
) (
  input  logic [SEG_WIDTH-1:0] a_i,
  input  logic [SEG_WIDTH-1:0] b_i,
  input  logic                 rin_i,
  output logic [SEG_WIDTH-1:0] s_o,
  output logic                 rout_o,
  output logic                 cmsb_o
);

  logic [SEG_WIDTH:0] full_s;

  assign full_s = {1'b0, a_i} + {1'b0, b_i} + {{SEG_WIDTH{1'b0}}, rin_i};
  assign s_o    = full_s[SEG_WIDTH-1:0];
  assign rout_o = full_s[SEG_WIDTH];
  // sum_msb = a_msb ^ b_msb ^ carry_in_msb, so the MSB carry-in is recovered
  // without a separate narrower adder (also valid for SEG_WIDTH = 1).
  assign cmsb_o = full_s[SEG_WIDTH-1] ^ a_i[SEG_WIDTH-1] ^ b_i[SEG_WIDTH-1];

endmodule

// File: rtl/additionneur_pipeline.sv
// -----------------------------------------------------------------------------
// additionneur_pipeline
// WIDTH-bit adder/subtractor split into NSEG = WIDTH/SEG_WIDTH pipeline stages.
// Stage k adds operand segment k using the carry registered by stage k-1.
// Operands not yet added travel forward with each stage, and the already
// computed low result segments travel with them, so one operation's full
// result leaves the last stage in one piece after exactly NSEG cycles.
// Ports:
//   clk : rising-edge clock
//   rst : asynchronous active-high reset (clears valids and outputs)
//   bus : slave side of additionneur_pipeline_if (operands in, result out)
// Flow control: the whole pipeline advances when the output slot is empty or
// being consumed; in_ready is that same enable. Bubbles advance unchanged.
// -----------------------------------------------------------------------------
module additionneur_pipeline
  import additionneur_pkg::*;
#(
  parameter int unsigned WIDTH     = ADD_WIDTH,
  parameter int unsigned SEG_WIDTH = ADD_SEG_WIDTH
) (
  input  logic                   clk,
  input  logic                   rst,
  additionneur_pipeline_if.slave bus
);

  localparam int unsigned NSEG = nseg(WIDTH, SEG_WIDTH);

  logic             adv_s;
  logic [WIDTH-1:0] b_in_s;
  logic             cin0_s;

  // Per-stage next-state values and stage registers.
  logic             valid_d [NSEG];
  logic             valid_q [NSEG];
  logic             carry_d [NSEG];
  logic             carry_q [NSEG];
  logic             cmsb_s  [NSEG];
  logic [WIDTH-1:0] res_d   [NSEG];
  logic [WIDTH-1:0] res_q   [NSEG];
  logic [WIDTH-1:0] a_d     [NSEG];
  logic [WIDTH-1:0] a_q     [NSEG];
  logic [WIDTH-1:0] b_d     [NSEG];
  logic [WIDTH-1:0] b_q     [NSEG];
  logic             ovf_d;
  logic             ovf_q;

  // A stalled result blocks every stage; otherwise everything moves.
  assign adv_s = ~valid_q[NSEG-1] | bus.out_ready;

  // Subtraction is a + ~b + 1: invert b once here and force the LSB carry.
  always_comb begin
    b_in_s = bus.b;
    cin0_s = bus.rin;
    case (op_e'(bus.sub))
      OP_SUB: begin
        b_in_s = ~bus.b;
        cin0_s = 1'b1;
      end
      OP_ADD: begin
        b_in_s = bus.b;
        cin0_s = bus.rin;
      end
      default: begin
        b_in_s = bus.b;
        cin0_s = bus.rin;
      end
    endcase
  end

  for (genvar k = 0; k < NSEG; k++) begin : g_stage
    logic [WIDTH-1:0]     pa_s;
    logic [WIDTH-1:0]     pb_s;
    logic [WIDTH-1:0]     pres_s;
    logic                 pc_s;
    logic                 pv_s;
    logic [SEG_WIDTH-1:0] ss_s;
    logic                 sco_s;
    logic [WIDTH-1:0]     res_s;

    if (k == 32'sd0) begin : g_src
      assign pa_s   = bus.a;
      assign pb_s   = b_in_s;
      assign pres_s = '0;
      assign pc_s   = cin0_s;
      assign pv_s   = bus.in_valid;
    end else begin : g_src
      assign pa_s   = a_q[k-32'sd1];
      assign pb_s   = b_q[k-32'sd1];
      assign pres_s = res_q[k-32'sd1];
      assign pc_s   = carry_q[k-32'sd1];
      assign pv_s   = valid_q[k-32'sd1];
    end

    additionneur_segment #(
      .SEG_WIDTH(SEG_WIDTH)
    ) u_seg (
      .a_i   (pa_s[k*SEG_WIDTH +: SEG_WIDTH]),
      .b_i   (pb_s[k*SEG_WIDTH +: SEG_WIDTH]),
      .rin_i (pc_s),
      .s_o   (ss_s),
      .rout_o(sco_s),
      .cmsb_o(cmsb_s[k])
    );

    // Insert this stage's segment into the result carried from upstream.
    always_comb begin
      res_s                            = pres_s;
      res_s[k*SEG_WIDTH +: SEG_WIDTH]  = ss_s;
    end

    assign res_d[k]   = res_s;
    assign a_d[k]     = pa_s;
    assign b_d[k]     = pb_s;
    assign carry_d[k] = sco_s;
    assign valid_d[k] = pv_s;
  end

  // Signed overflow only depends on the top segment's MSB carries.
  assign ovf_d = cmsb_s[NSEG-1] ^ carry_d[NSEG-1];

  // Stage registers: async clear, load together on advance, hold otherwise.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 32'd0; i < NSEG; i++) begin
        valid_q[i] <= 1'b0;
        carry_q[i] <= 1'b0;
        res_q[i]   <= '0;
        a_q[i]     <= '0;
        b_q[i]     <= '0;
      end
      ovf_q <= 1'b0;
    end else if (adv_s) begin
      for (int unsigned i = 32'd0; i < NSEG; i++) begin
        valid_q[i] <= valid_d[i];
        carry_q[i] <= carry_d[i];
        res_q[i]   <= res_d[i];
        a_q[i]     <= a_d[i];
        b_q[i]     <= b_d[i];
      end
      ovf_q <= ovf_d;
    end
  end

  assign bus.in_ready  = adv_s;
  assign bus.out_valid = valid_q[NSEG-1];
  assign bus.s         = res_q[NSEG-1];
  assign bus.rout      = carry_q[NSEG-1];
  assign bus.ovf       = ovf_q;

endmodule

// File: tb/tb_additionneur_pipeline.sv
// -----------------------------------------------------------------------------
// tb_additionneur_pipeline
// Self-checking bench for additionneur_pipeline with WIDTH=32, SEG_WIDTH=16.
// Expected results come from plain 64-bit integer arithmetic on the operands.
// -----------------------------------------------------------------------------
module tb_additionneur_pipeline;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  additionneur_pipeline_if #(.WIDTH(32)) bus ();

  additionneur_pipeline #(
    .WIDTH    (32),
    .SEG_WIDTH(16)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  // Reference: {ovf, rout, s} of a + b + rin, or a - b.
  function automatic logic [33:0] ref_op(input logic [31:0] a, input logic [31:0] b,
                                         input logic rin, input logic sub);
    longint ua, ub, sa, sb, r, sr;
    logic [31:0] s;
    logic c, v;
    ua = longint'({32'd0, a});
    ub = longint'({32'd0, b});
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    if (sub) begin
      r  = ua - ub;
      c  = (ua >= ub);
      sr = sa - sb;
    end else begin
      r  = ua + ub + longint'(rin);
      c  = (r > 64'sd4294967295);
      sr = sa + sb + longint'(rin);
    end
    s = r[31:0];
    v = (sr > 64'sd2147483647) || (sr < -64'sd2147483648);
    return {v, c, s};
  endfunction

  task automatic drive_op(input logic v, input logic [31:0] a, input logic [31:0] b,
                          input logic rin, input logic sub);
    bus.in_valid = v;
    bus.a        = a;
    bus.b        = b;
    bus.rin      = rin;
    bus.sub      = sub;
  endtask

  task automatic test_reset();
    drive_op(1'b0, 32'd0, 32'd0, 1'b0, 1'b0);
    bus.out_ready = 1'b0;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (bus.out_valid !== 1'b0) begin
      errors++; $display("FAIL reset_out_valid got=%b exp=0", bus.out_valid);
    end
    checks++;
    if ({bus.ovf, bus.rout, bus.s} !== 34'd0) begin
      errors++; $display("FAIL reset_outputs got=%h exp=0", {bus.ovf, bus.rout, bus.s});
    end
    checks++;
    if (bus.in_ready !== 1'b1) begin
      errors++; $display("FAIL reset_in_ready got=%b exp=1", bus.in_ready);
    end
    rst = 1'b0;
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
      errors++; $display("FAIL post_reset_idle got v=%b r=%b exp v=0 r=1", bus.out_valid, bus.in_ready);
    end
  endtask

  task automatic test_directed();
    logic [31:0] ta [5] = '{32'h0000FFFF, 32'h7FFFFFFF, 32'h00000005, 32'hFFFFFFFF, 32'h80000000};
    logic [31:0] tb [5] = '{32'h00000001, 32'h00000001, 32'h00000007, 32'h00000000, 32'h00000001};
    logic        tr [5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    logic        tu [5] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    logic [33:0] te [5] = '{{1'b0, 1'b0, 32'h00010000}, {1'b1, 1'b0, 32'h80000000},
                            {1'b0, 1'b0, 32'hFFFFFFFE}, {1'b0, 1'b1, 32'h00000000},
                            {1'b1, 1'b1, 32'h7FFFFFFF}};
    bus.out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      drive_op(1'b1, ta[i], tb[i], tr[i], tu[i]);
      @(posedge clk); #1;
      drive_op(1'b0, 32'd0, 32'd0, 1'b0, 1'b0);
      checks++;
      if (bus.out_valid !== 1'b0) begin
        errors++; $display("FAIL dir%0d_early_valid got=%b exp=0", i, bus.out_valid);
      end
      @(posedge clk); #1;
      checks++;
      if (bus.out_valid !== 1'b1) begin
        errors++; $display("FAIL dir%0d_latency got=%b exp=1", i, bus.out_valid);
      end
      checks++;
      if ({bus.ovf, bus.rout, bus.s} !== te[i]) begin
        errors++; $display("FAIL dir%0d_result got=%h exp=%h", i, {bus.ovf, bus.rout, bus.s}, te[i]);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_back_to_back();
    logic [33:0] exp_arr [100];
    logic [31:0] a, b;
    logic rin, sub;
    bus.out_ready = 1'b1;
    for (int i = 0; i < 102; i++) begin
      checks++;
      if (bus.out_valid !== (i >= 2)) begin
        errors++; $display("FAIL b2b_valid cycle=%0d got=%b exp=%b", i, bus.out_valid, (i >= 2));
      end
      if (i >= 2) begin
        checks++;
        if ({bus.ovf, bus.rout, bus.s} !== exp_arr[i-2]) begin
          errors++; $display("FAIL b2b_data op=%0d got=%h exp=%h", i - 2, {bus.ovf, bus.rout, bus.s}, exp_arr[i-2]);
        end
      end
      if (i < 100) begin
        a = $urandom; b = $urandom;
        rin = 1'($urandom_range(0, 1)); sub = 1'($urandom_range(0, 1));
        if (i % 10 == 3) a = 32'hFFFFFFFF;
        drive_op(1'b1, a, b, rin, sub);
        exp_arr[i] = ref_op(a, b, rin, sub);
      end else begin
        drive_op(1'b0, 32'd0, 32'd0, 1'b0, 1'b0);
      end
      @(posedge clk); #1;
    end
  endtask

  // rnd=0: full pipeline then five stalled cycles; rnd=1: random valid/ready.
  task automatic test_flow(input bit rnd, input int n_in);
    logic [33:0] q [$];
    logic [33:0] got, prev_out;
    bit prev_stall, ordy, exp_rdy, ivld;
    int accepted, received;
    logic [31:0] a, b;
    logic rin, sub;
    prev_stall = 1'b0; prev_out = '0; accepted = 0; received = 0;
    for (int c = 0; c < n_in + 60; c++) begin
      if (c >= n_in && q.size() == 0 && bus.out_valid !== 1'b1) break;
      ordy = rnd ? ($urandom_range(0, 3) != 0) : !(c >= 4 && c < 9);
      bus.out_ready = ordy;
      got = {bus.ovf, bus.rout, bus.s};
      exp_rdy = !bus.out_valid || ordy;
      if (bus.out_valid) begin
        if (prev_stall) begin
          checks++;
          if (got !== prev_out) begin
            errors++; $display("FAIL flow_stable cycle=%0d got=%h exp=%h", c, got, prev_out);
          end
        end
        if (ordy) begin
          checks++;
          if (q.size() == 0) begin
            errors++; $display("FAIL flow_extra cycle=%0d got=%h exp=none", c, got);
          end else begin
            if (got !== q[0]) begin
              errors++; $display("FAIL flow_data cycle=%0d got=%h exp=%h", c, got, q[0]);
            end
            void'(q.pop_front());
          end
          received++;
        end
      end
      prev_stall = bus.out_valid && !ordy;
      prev_out = got;
      ivld = (c < n_in) && (rnd ? ($urandom_range(0, 3) != 0) : 1'b1);
      a = $urandom; b = $urandom;
      rin = 1'($urandom_range(0, 1)); sub = 1'($urandom_range(0, 1));
      drive_op(ivld, a, b, rin, sub);
      if (ivld && exp_rdy) begin
        q.push_back(ref_op(a, b, rin, sub));
        accepted++;
      end
      #1;
      checks++;
      if (bus.in_ready !== exp_rdy) begin
        errors++; $display("FAIL flow_in_ready cycle=%0d got=%b exp=%b", c, bus.in_ready, exp_rdy);
      end
      @(posedge clk); #1;
    end
    drive_op(1'b0, 32'd0, 32'd0, 1'b0, 1'b0);
    bus.out_ready = 1'b1;
    checks++;
    if (q.size() != 0 || received != accepted) begin
      errors++; $display("FAIL flow_count got=%0d results exp=%0d (left=%0d)", received, accepted, q.size());
    end
  endtask

  task automatic test_reset_in_flight();
    logic [31:0] a, b;
    logic [33:0] e;
    bus.out_ready = 1'b1;
    drive_op(1'b1, $urandom, $urandom, 1'b0, 1'b0);
    @(posedge clk); #1;
    drive_op(1'b1, $urandom, $urandom, 1'b1, 1'b1);
    @(posedge clk); #1;
    drive_op(1'b0, 32'd0, 32'd0, 1'b0, 1'b0);
    bus.out_ready = 1'b0;
    rst = 1'b1;
    #1;
    checks++;
    if (bus.out_valid !== 1'b0 || {bus.ovf, bus.rout, bus.s} !== 34'd0) begin
      errors++; $display("FAIL rst_flight_clear got v=%b r=%h exp v=0 r=0", bus.out_valid, {bus.ovf, bus.rout, bus.s});
    end
    checks++;
    if (bus.in_ready !== 1'b1) begin
      errors++; $display("FAIL rst_flight_in_ready got=%b exp=1", bus.in_ready);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    bus.out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      checks++;
      if (bus.out_valid !== 1'b0) begin
        errors++; $display("FAIL rst_flight_ghost cycle=%0d got=%b exp=0", i, bus.out_valid);
      end
    end
    a = $urandom; b = $urandom;
    e = ref_op(a, b, 1'b1, 1'b0);
    drive_op(1'b1, a, b, 1'b1, 1'b0);
    @(posedge clk); #1;
    drive_op(1'b0, 32'd0, 32'd0, 1'b0, 1'b0);
    checks++;
    if (bus.out_valid !== 1'b0) begin
      errors++; $display("FAIL rst_after_early got=%b exp=0", bus.out_valid);
    end
    @(posedge clk); #1;
    checks++;
    if (bus.out_valid !== 1'b1 || {bus.ovf, bus.rout, bus.s} !== e) begin
      errors++; $display("FAIL rst_after_result got v=%b r=%h exp v=1 r=%h", bus.out_valid, {bus.ovf, bus.rout, bus.s}, e);
    end
    @(posedge clk); #1;
  endtask

  initial begin
    test_reset();
    test_directed();
    test_back_to_back();
    test_flow(1'b0, 12);
    test_flow(1'b1, 150);
    test_reset_in_flight();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout errors=%0d checks=%0d", errors, checks);
    $fatal(1, "watchdog");
  end

endmodule
